// File: rtl/jam_perm_sched_if.sv
// Handshake/bus bundle for the permutation scheduler.
//   master : scheduler side (drives load strobe/address, permutation stream, status)
//   slave  : consumer / controlling side (drives start and perm_ready)
// Signals: start, load_en, load_w, load_j, perm_valid, perm_ready, perm_job,
//          perm_last, perm_idx, busy, done.
interface jam_perm_sched_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned CNT_W = 16
);
  logic                 start;
  logic                 load_en;
  logic [IDX_W-1:0]     load_w;
  logic [IDX_W-1:0]     load_j;
  logic                 perm_valid;
  logic                 perm_ready;
  logic [N*IDX_W-1:0]   perm_job;
  logic                 perm_last;
  logic [CNT_W-1:0]     perm_idx;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, perm_ready,
    output load_en, load_w, load_j, perm_valid, perm_job, perm_last, perm_idx, busy, done
  );

  modport slave (
    output start, perm_ready,
    input  load_en, load_w, load_j, perm_valid, perm_job, perm_last, perm_idx, busy, done
  );
endinterface

// File: rtl/jam_perm_sched.sv
// Job-assignment cost datapath sequencer.
// Raster-addresses the N x N cost table for loading, then emits every permutation of
// N jobs in lexicographic order over valid/ready, raising a sticky done after the
// descending permutation is accepted.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      jam_perm_sched_if.master (start, load_*, perm_*, busy, done)
// Build option: JAM_PIVOT_COMB_EN finds pivot and successor in a single cycle
// (FIND_SUCC becomes unreachable); the emitted sequence is unchanged.
module jam_perm_sched #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  jam_perm_sched_if.master       bus
);

  localparam logic [IDX_W-1:0] IdxMax = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IdxOne = IDX_W'(1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StIssue, StFindPivot, StFindSucc, StSwap, StReverse, StDone
  } state_e;

  state_e           r_state, w_state_d;
  logic [IDX_W-1:0] r_job [N];
  logic [IDX_W-1:0] w_job_d [N];
  logic [CNT_W-1:0] r_idx, w_idx_d;
  logic             r_done, w_done_d;
  logic [IDX_W-1:0] r_w, w_w_d, r_j, w_j_d;     // load address
  logic [IDX_W-1:0] r_i, w_i_d, r_k, w_k_d;     // pivot / successor index
  logic [IDX_W-1:0] r_lo, w_lo_d, r_hi, w_hi_d; // suffix reversal bounds
  logic [IDX_W-1:0] w_lo_inc, w_hi_dec;
  logic             w_last;

  assign w_lo_inc = r_lo + IdxOne;
  assign w_hi_dec = r_hi - IdxOne;

  // Descending order marks the final permutation.
  always_comb begin
    w_last = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (r_job[k] != IDX_W'(N - 1 - k)) w_last = 1'b0;
    end
  end

`ifdef JAM_PIVOT_COMB_EN
  logic [IDX_W-1:0] w_piv, w_succ;

  // Ascending scans so the highest qualifying index wins.
  always_comb begin
    w_piv = '0;
    for (int k = 0; k < N - 1; k++) begin
      if (r_job[k] < r_job[k+1]) w_piv = IDX_W'(k);
    end
    w_succ = '0;
    for (int k = 0; k < N; k++) begin
      if (r_job[k] > r_job[w_piv]) w_succ = IDX_W'(k);
    end
  end
`endif

  always_comb begin
    w_state_d = r_state;
    w_job_d   = r_job;
    w_idx_d   = r_idx;
    w_done_d  = r_done;
    w_w_d     = r_w;
    w_j_d     = r_j;
    w_i_d     = r_i;
    w_k_d     = r_k;
    w_lo_d    = r_lo;
    w_hi_d    = r_hi;
    unique case (r_state)
      StIdle, StDone: begin
        if (bus.start) begin
          w_state_d = StLoad;
          for (int k = 0; k < N; k++) w_job_d[k] = IDX_W'(k);
          w_idx_d  = '0;
          w_done_d = 1'b0;
          w_w_d    = '0;
          w_j_d    = '0;
        end
      end
      StLoad: begin
        if (r_j == IdxMax) begin
          w_j_d = '0;
          if (r_w == IdxMax) begin
            w_w_d     = '0;
            w_state_d = StIssue;
          end else begin
            w_w_d = r_w + IdxOne;
          end
        end else begin
          w_j_d = r_j + IdxOne;
        end
      end
      StIssue: begin
        if (bus.perm_ready) begin
          if (w_last) begin
            w_state_d = StDone;
            w_done_d  = 1'b1;
          end else begin
            w_idx_d   = r_idx + CNT_W'(1);
            w_i_d     = IDX_W'(N - 2);
            w_state_d = StFindPivot;
          end
        end
      end
      StFindPivot: begin
`ifdef JAM_PIVOT_COMB_EN
        w_i_d     = w_piv;
        w_k_d     = w_succ;
        w_state_d = StSwap;
`else
        if (r_job[r_i] < r_job[r_i + IdxOne]) begin
          w_k_d     = IdxMax;
          w_state_d = StFindSucc;
        end else begin
          w_i_d = r_i - IdxOne;
        end
`endif
      end
      StFindSucc: begin
        if (r_job[r_k] > r_job[r_i]) w_state_d = StSwap;
        else                         w_k_d     = r_k - IdxOne;
      end
      StSwap: begin
        w_job_d[r_i] = r_job[r_k];
        w_job_d[r_k] = r_job[r_i];
        w_lo_d       = r_i + IdxOne;
        w_hi_d       = IdxMax;
        w_state_d    = StReverse;
      end
      StReverse: begin
        if (r_lo < r_hi) begin
          w_job_d[r_lo] = r_job[r_hi];
          w_job_d[r_hi] = r_job[r_lo];
          w_lo_d        = w_lo_inc;
          w_hi_d        = w_hi_dec;
          // lo < hi guarantees neither increment nor decrement wraps.
          if (w_lo_inc >= w_hi_dec) w_state_d = StIssue;
        end else begin
          w_state_d = StIssue;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      for (int k = 0; k < N; k++) r_job[k] <= IDX_W'(k);
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_w     <= '0;
      r_j     <= '0;
      r_i     <= '0;
      r_k     <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_state_d;
      r_job   <= w_job_d;
      r_idx   <= w_idx_d;
      r_done  <= w_done_d;
      r_w     <= w_w_d;
      r_j     <= w_j_d;
      r_i     <= w_i_d;
      r_k     <= w_k_d;
      r_lo    <= w_lo_d;
      r_hi    <= w_hi_d;
    end
  end

  always_comb begin
    bus.load_en    = (r_state == StLoad);
    bus.load_w     = r_w;
    bus.load_j     = r_j;
    bus.perm_valid = (r_state == StIssue);
    bus.perm_last  = w_last;
    bus.perm_idx   = r_idx;
    bus.busy       = (r_state != StIdle) && (r_state != StDone);
    bus.done       = r_done;
    bus.perm_job   = '0;
    for (int k = 0; k < N; k++) bus.perm_job[k*IDX_W +: IDX_W] = r_job[k];
  end

endmodule

// File: tb/tb_jam_perm_sched.sv
// Bench for jam_perm_sched: an N=8 instance for load/gap/stall/reset scenarios and an
// N=5 instance that is run to completion. Expected permutations come from the
// factorial-number-system decoding of the permutation ordinal.
module tb_jam_perm_sched;

`ifdef JAM_PIVOT_COMB_EN
  localparam int ExpGap = 4;
`else
  localparam int ExpGap = 5;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   big_next = 0;

  always #5 clk = ~clk;

  jam_perm_sched_if #(.N(8), .IDX_W(3), .CNT_W(16)) bus8 ();
  jam_perm_sched_if #(.N(5), .IDX_W(3), .CNT_W(8))  bus5 ();

  jam_perm_sched #(.N(8), .IDX_W(3), .CNT_W(16)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus8)
  );
  jam_perm_sched #(.N(5), .IDX_W(3), .CNT_W(8)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus5)
  );

  function automatic int fact(input int n);
    int f = 1;
    for (int k = 2; k <= n; k++) f = f * k;
    return f;
  endfunction

  // Permutation number idx (lexicographic) of 0..n-1, packed 3 bits per worker.
  function automatic logic [23:0] perm_at(input int n, input int idx);
    int avail[8];
    int cnt = n;
    int rem = idx;
    logic [23:0] v = '0;
    for (int k = 0; k < 8; k++) avail[k] = k;
    for (int pos = 0; pos < n; pos++) begin
      int f;
      int d;
      f = fact(n - 1 - pos);
      d = rem / f;
      rem = rem % f;
      v[pos*3 +: 3] = 3'(avail[d]);
      for (int m = d; m < cnt - 1; m++) avail[m] = avail[m+1];
      cnt--;
    end
    return v;
  endfunction

  // Cycle (1-based, after the accept edge) in which the suffix reversal runs.
  function automatic int rev_cycle(input logic [23:0] v);
    int p[8];
    int pi = 0;
    int pj = 0;
    for (int k = 0; k < 8; k++) p[k] = int'(v[k*3 +: 3]);
    for (int k = 0; k < 7; k++) if (p[k] < p[k+1]) pi = k;
    for (int k = 0; k < 8; k++) if (p[k] > p[pi]) pj = k;
`ifdef JAM_PIVOT_COMB_EN
    return 3;
`else
    return (7 - pi) + (8 - pj) + 2;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    total++;
    if ({bus8.load_en, bus8.perm_valid, bus8.busy, bus8.done, bus8.perm_last} !== 5'b0) begin
      bad++;
      $display("FAIL %s_flags got=%b want=00000", tag,
               {bus8.load_en, bus8.perm_valid, bus8.busy, bus8.done, bus8.perm_last});
    end
    total++;
    if (bus8.perm_idx !== 16'd0 || bus8.perm_job !== perm_at(8, 0)) begin
      bad++;
      $display("FAIL %s_job got=%h/%0d want=%h/0", tag, bus8.perm_job, bus8.perm_idx,
               perm_at(8, 0));
    end
  endtask

  task automatic test_reset();
    bus8.start = 1'b0; bus8.perm_ready = 1'b0;
    bus5.start = 1'b0; bus5.perm_ready = 1'b0;
    rst_n = 1'b0;
    step(); step();
    check_cleared("reset");
    total++;
    if ({bus5.perm_valid, bus5.busy, bus5.done, bus5.load_en} !== 4'b0) begin
      bad++;
      $display("FAIL reset_small got=%b want=0000",
               {bus5.perm_valid, bus5.busy, bus5.done, bus5.load_en});
    end
    rst_n = 1'b1;
    step();
  endtask

  // Start pulse, 64 raster writes, first permutation presented.
  task automatic test_load(input bit poke);
    int n = 0;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    for (int c = 0; c < 200 && bus8.load_en === 1'b1; c++) begin
      total++;
      if ({bus8.load_w, bus8.load_j} !== {3'(n / 8), 3'(n % 8)}) begin
        bad++;
        $display("FAIL load_addr got=(%0d,%0d) want=(%0d,%0d)", bus8.load_w, bus8.load_j,
                 n / 8, n % 8);
      end
      bus8.start = (poke && n == 10);
      n++;
      step();
    end
    bus8.start = 1'b0;
    total++;
    if (n != 64) begin
      bad++; $display("FAIL load_count got=%0d want=64", n);
    end
    total++;
    if (bus8.perm_valid !== 1'b1 || bus8.perm_idx !== 16'd0 || bus8.perm_job !== perm_at(8, 0)
        || bus8.busy !== 1'b1) begin
      bad++;
      $display("FAIL first_perm got=v%b/%0d/%h want=v1/0/%h", bus8.perm_valid, bus8.perm_idx,
               bus8.perm_job, perm_at(8, 0));
    end
    big_next = 0;
  endtask

  task automatic test_first_gap();
    int gap = 1;
    bus8.perm_ready = 1'b1;
    step();
    while (bus8.perm_valid !== 1'b1 && gap < 50) begin
      gap++;
      step();
    end
    bus8.perm_ready = 1'b0;
    big_next = 1;
    total++;
    if (gap != ExpGap) begin
      bad++; $display("FAIL first_gap got=%0d want=%0d", gap, ExpGap);
    end
    total++;
    if (bus8.perm_job !== perm_at(8, 1) || bus8.perm_idx !== 16'd1 || bus8.perm_last !== 1'b0)
    begin
      bad++;
      $display("FAIL second_perm got=%h/%0d want=%h/1", bus8.perm_job, bus8.perm_idx,
               perm_at(8, 1));
    end
  endtask

  // Backpressure holds the presented permutation; start in ISSUE is ignored.
  task automatic test_stall();
    int hold = $urandom_range(8, 12);
    bus8.perm_ready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      total++;
      if (bus8.perm_valid !== 1'b1 || bus8.perm_job !== perm_at(8, big_next) ||
          int'(bus8.perm_idx) != big_next) begin
        bad++;
        $display("FAIL stall_hold got=v%b/%h/%0d want=v1/%h/%0d", bus8.perm_valid,
                 bus8.perm_job, bus8.perm_idx, perm_at(8, big_next), big_next);
      end
      bus8.start = (c == 3);
      step();
    end
    bus8.start = 1'b0;
    bus8.perm_ready = 1'b1;
    step();
    bus8.perm_ready = 1'b0;
    big_next++;
    total++;
    if (int'(bus8.perm_idx) != big_next || bus8.perm_valid !== 1'b0 || bus8.busy !== 1'b1) begin
      bad++;
      $display("FAIL stall_accept got=%0d/v%b/b%b want=%0d/v0/b1", bus8.perm_idx,
               bus8.perm_valid, bus8.busy, big_next);
    end
  endtask

  task automatic test_random_run(input int count);
    int accepted = 0;
    for (int cyc = 0; cyc < 40000 && accepted < count; cyc++) begin
      bit rdy = ($urandom_range(0, 3) != 0);
      if (bus8.perm_valid === 1'b1) begin
        total++;
        if (bus8.perm_job !== perm_at(8, big_next) || int'(bus8.perm_idx) != big_next ||
            bus8.perm_last !== 1'b0) begin
          bad++;
          $display("FAIL run_perm got=%h/%0d/l%b want=%h/%0d/l0", bus8.perm_job,
                   bus8.perm_idx, bus8.perm_last, perm_at(8, big_next), big_next);
        end
        if (rdy) begin
          accepted++;
          big_next++;
        end
      end
      bus8.perm_ready = rdy;
      step();
    end
    bus8.perm_ready = 1'b0;
    total++;
    if (accepted != count) begin
      bad++; $display("FAIL run_count got=%0d want=%0d", accepted, count);
    end
  endtask

  // Small instance: full sequence, last flag, sticky done.
  task automatic test_complete();
    int n = 0;
    int e = 0;
    bus5.start = 1'b1;
    step();
    bus5.start = 1'b0;
    for (int c = 0; c < 100 && bus5.load_en === 1'b1; c++) begin
      n++;
      step();
    end
    total++;
    if (n != 25) begin
      bad++; $display("FAIL small_load got=%0d want=25", n);
    end
    for (int cyc = 0; cyc < 5000 && bus5.done !== 1'b1; cyc++) begin
      bit rdy = ($urandom_range(0, 2) != 0);
      if (bus5.perm_valid === 1'b1) begin
        total++;
        if (24'(bus5.perm_job) !== perm_at(5, e) || int'(bus5.perm_idx) != e ||
            bus5.perm_last !== (e == 119)) begin
          bad++;
          $display("FAIL small_perm got=%h/%0d/l%b want=%h/%0d/l%0d", bus5.perm_job,
                   bus5.perm_idx, bus5.perm_last, perm_at(5, e), e, (e == 119));
        end
        if (rdy) e++;
      end
      bus5.perm_ready = rdy;
      step();
    end
    bus5.perm_ready = 1'b0;
    step(); step(); step();
    total++;
    if (e != 120 || bus5.done !== 1'b1 || bus5.busy !== 1'b0 || bus5.perm_valid !== 1'b0) begin
      bad++;
      $display("FAIL small_done got=n%0d/d%b/b%b/v%b want=n120/d1/b0/v0", e, bus5.done,
               bus5.busy, bus5.perm_valid);
    end
    total++;
    if (24'(bus5.perm_job) !== perm_at(5, 119) || bus5.perm_idx !== 8'd119) begin
      bad++;
      $display("FAIL small_final got=%h/%0d want=%h/119", bus5.perm_job, bus5.perm_idx,
               perm_at(5, 119));
    end
  endtask

  task automatic test_restart_done();
    bus5.start = 1'b1;
    step();
    bus5.start = 1'b0;
    total++;
    if (bus5.done !== 1'b0 || bus5.load_en !== 1'b1 || bus5.busy !== 1'b1 ||
        {bus5.load_w, bus5.load_j} !== 6'd0 || bus5.perm_idx !== 8'd0 ||
        24'(bus5.perm_job) !== perm_at(5, 0)) begin
      bad++;
      $display("FAIL restart got=d%b/le%b/(%0d,%0d)/%0d/%h want=d0/le1/(0,0)/0/%h", bus5.done,
               bus5.load_en, bus5.load_w, bus5.load_j, bus5.perm_idx, bus5.perm_job,
               perm_at(5, 0));
    end
  endtask

  task automatic test_reset_mid_reverse();
    int c;
    for (int k = 0; k < 100 && bus8.perm_valid !== 1'b1; k++) step();
    total++;
    if (bus8.perm_valid !== 1'b1) begin
      bad++; $display("FAIL rst_wait got=v%b want=v1", bus8.perm_valid);
    end
    c = rev_cycle(perm_at(8, big_next));
    bus8.perm_ready = 1'b1;
    step();
    bus8.perm_ready = 1'b0;
    for (int k = 1; k < c; k++) step();
    rst_n = 1'b0;
    #1;
    check_cleared("midrst");
    step(); step();
    rst_n = 1'b1;
    step();
    test_load(1'b0);
  endtask

  initial begin
    test_reset();
    test_load(1'b1);
    test_first_gap();
    test_stall();
    test_random_run(1500);
    test_complete();
    test_restart_done();
    test_reset_mid_reverse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
